// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe
// ------------------
// Pipelined ShiftRows / InvShiftRows stage for the Rijndael round datapath.
// Each accepted beat has its bytes permuted on the way into the first
// register stage. Further stages only carry the beat towards the output.
// A valid/ready handshake gives full back-pressure and has no bubbles.
//
// Parameters
//   NB           state columns (4, 6 or 8)
//   PIPE_STAGES  number of register stages (1..4)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every in-flight beat
//   in_valid   input beat valid
//   in_ready   block can accept an input beat
//   in_inv     0 = ShiftRows, 1 = InvShiftRows, sampled with the beat
//   in_state   input state, column-major, MSB first
//   out_valid  output beat valid
//   out_ready  downstream accepts the beat
//   out_inv    mode bit carried with the beat
//   out_state  permuted state
//   busy       at least one stage holds a valid beat
module aes_shiftrows_pipe #(
  parameter int NB          = 4,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [32*NB-1:0]  out_state,
  output logic              busy
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("aes_shiftrows_pipe: PIPE_STAGES must be in 1..4");
  end

  // Byte permutation. All indices are elaboration-time constants, so this
  // reduces to plain wiring plus a 2:1 mux per byte for the mode select.
  // The wide block (NB = 8) uses row offsets {0,1,3,4}. The others use
  // {0,1,2,3}.
  logic [W-1:0] perm_state;

  for (genvar r = 0; r < 4; r++) begin : g_row
    localparam int OFF = ((NB == 8) && (r >= 2)) ? r + 1 : r;
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FSRC = (c + OFF) % NB;
      localparam int ISRC = (c - OFF + NB) % NB;
      localparam int DST  = W - 1 - 8 * (r + 4 * c);
      localparam int FBIT = W - 1 - 8 * (r + 4 * FSRC);
      localparam int IBIT = W - 1 - 8 * (r + 4 * ISRC);
      assign perm_state[DST -: 8] = in_inv ? in_state[IBIT -: 8]
                                           : in_state[FBIT -: 8];
    end
  end

  logic [PIPE_STAGES-1:0] valid_vec;

  // Elastic register chain. A stage takes a new beat when it is empty or
  // its own beat is leaving in the same cycle. The ready chain therefore
  // runs combinationally from out_ready back to in_ready.
  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic         valid_q;
    logic         inv_q;
    logic [W-1:0] state_q;
    logic         rdy;
    logic         down_rdy;
    logic         up_valid;
    logic         up_inv;
    logic [W-1:0] up_state;

    if (k == PIPE_STAGES - 1) begin : g_last
      assign down_rdy = out_ready;
    end else begin : g_mid
      assign down_rdy = g_stage[k+1].rdy;
    end

    if (k == 0) begin : g_first
      assign up_valid = in_valid && !flush;
      assign up_inv   = in_inv;
      assign up_state = perm_state;
    end else begin : g_follow
      assign up_valid = g_stage[k-1].valid_q;
      assign up_inv   = g_stage[k-1].inv_q;
      assign up_state = g_stage[k-1].state_q;
    end

    assign rdy          = !valid_q || down_rdy;
    assign valid_vec[k] = valid_q;

    // The payload loads only when a beat actually moves in. A stalled
    // stage therefore keeps its data bit-exact.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        inv_q   <= 1'b0;
        state_q <= '0;
      end else begin
        if (flush) begin
          valid_q <= 1'b0;
        end else if (rdy) begin
          valid_q <= up_valid;
        end
        if (rdy && up_valid) begin
          inv_q   <= up_inv;
          state_q <= up_state;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy && !flush;
  assign out_valid = g_stage[PIPE_STAGES-1].valid_q;
  assign out_inv   = g_stage[PIPE_STAGES-1].inv_q;
  assign out_state = g_stage[PIPE_STAGES-1].state_q;
  assign busy      = |valid_vec;

endmodule

// File: doc/aes_shiftrows_pipe.md
# aes_shiftrows_pipe

Parametrised, pipelined ShiftRows / InvShiftRows stage for the AES/Rijndael datapath. It accepts one state block per beat on a valid/ready handshake and permutes its bytes in the forward or inverse direction, selected per beat. It supports Rijndael block widths of 4, 6 or 8 columns. Results leave after a configurable number of register stages with full back-pressure. It sits between the SubBytes and MixColumns stages of the round pipeline and can be reused in the decrypt path.

## Interface
- NB, default 4: state columns; legal values 4, 6, 8; any other value is an elaboration error.
- PIPE_STAGES, default 1: register stages; legal range 1..4; any other value is an elaboration error.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; one clock, reset asynchronous and active-low.
- flush  input  1  synchronous clear of all in-flight beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_inv  input  1  0 = ShiftRows (encrypt), 1 = InvShiftRows (decrypt); sampled with the beat.
- in_state  input  32*NB  input state.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_inv  output  1  mode bit carried with the beat.
- out_state  output  32*NB  permuted state.
- busy  output  1  at least one stage holds a valid beat.

## Operation
- Byte layout is column-major, MSB first.
  - Byte s[r][c] (r = 0..3, c = 0..NB-1) occupies bits [32*NB-1-8*(r+4c) -: 8].
- Row offsets:
  - NB = 4 or 6: C = {0,1,2,3}.
  - NB = 8: C = {0,1,3,4}.
- Forward: out[r][c] = in[r][(c + C[r]) mod NB].
- Inverse: out[r][c] = in[r][(c - C[r] + NB) mod NB].
- Row 0 is always unchanged.
- The permutation is combinational at the input and is registered into stage 1. Stages 2..PIPE_STAGES carry data and mode unchanged.
- Each stage holds a valid flag plus a {inv, state} payload.
- Stage k loads when stage k is empty or stage k+1 will accept in the same cycle. The last stage's downstream acceptance is out_ready.
  - in_ready = stage 1 empty OR stage 1 advancing this cycle. This is a combinational path from out_ready through the stage-enable chain; no bubbles are allowed.
- A beat is transferred when valid && ready on the same edge.
- Payload registers load only on transfer. A stalled stage holds its payload bit-exact.
- out_valid, out_state and out_inv are driven from the last stage. They stay stable while out_valid=1 and out_ready=0.
- flush=1 clears every stage valid flag at the next edge. Payload is don't-care after a flush.
  - in_ready=0 while flush=1, so a beat presented during flush is not accepted.
- busy = OR of all stage valid flags.

## Timing
- Reset (rst_n=0, asynchronous):
  - All stage valid flags, out_valid and busy go to 0 immediately.
  - out_state and out_inv reset to 0.
  - in_ready is 1 once reset has been released and flush=0.
- Latency: a beat accepted at edge t appears on out_valid after edge t+PIPE_STAGES-1, assuming no stalls. With PIPE_STAGES=1 the output is valid the cycle after acceptance.
- Throughput: one beat per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 and nothing is lost or overwritten. When out_ready returns to 1, in_ready rises in the same cycle.
- Simultaneous out transfer and in transfer on a full pipeline: both occur and occupancy is unchanged.
- Mode switches between consecutive beats take effect with no bubble. Each beat carries its own mode bit.
- Reset asserted mid-operation drops all in-flight beats. There is no partial output.
- flush and rst_n=0 together: reset dominates.

## Test plan
- FIPS-197 App. B, NB=4, in_inv=0:
  - in_state = d42711ae_e0bf98f1_b8b45de5_1e415230 -> out_state = d4bf5d30_e0b452ae_b84111f1_1e2798e5, out_inv=0, PIPE_STAGES cycles after acceptance.
  - Same vector reversed (in_inv=1, in = the result above) -> the original value.
- NB=8, in_inv=0:
  - in_state = 00_01_02_..._1f (byte i = i) -> out_state column 0 = 00,05,0e,13 and column 7 = 1c,01,0a,0f.
  - Then in_inv=1 restores 00..1f.
- Back-pressure, PIPE_STAGES=3:
  - Stream 10 random beats with out_ready toggling pseudo-randomly -> all 10 outputs appear in order, each equal to the reference-model permutation.
  - out_state stays stable on every stalled cycle, and in_ready=0 only when all 3 stages are full and out_ready=0.
- Alternating in_inv 0/1 on back-to-back beats at full rate:
  - Outputs alternate forward/inverse results.
  - out_inv matches each beat.
  - No idle cycles between outputs.
- Flush and reset:
  - With 3 beats in flight, pulse flush for one cycle -> busy=0 and out_valid=0 the next cycle, and no flushed beat ever appears at the output.
  - Repeat with rst_n pulsed low mid-cycle -> out_valid=0 asynchronously.
  - A new beat after release completes with normal latency.
